// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipeline_pkg;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } pc_state_e;

    localparam logic [4:0]  REG_ZERO       = 5'd0;
    localparam int unsigned MD_LATENCY_DEF = 32;
    localparam int unsigned MD_CNT_W       = 6;

    function automatic logic load_use_hit(
        input logic       memread,
        input logic [4:0] ex_rt,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       use_rs,
        input logic       use_rt
    );
        return memread && (ex_rt != REG_ZERO) &&
               ((use_rs && (ex_rt == rs)) || (use_rt && (ex_rt == rt)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         clr_ni,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!clr_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: load-use stall, branch/jump flush, mul/div wait.
// Optional mul/div wait state is enabled by defining PIPE_CTRL_MULDIV_EN.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned MD_LATENCY = MD_LATENCY_DEF,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_jop,
    input  logic             id_md_start,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    pc_state_e state_q;
    pc_state_e state_d;
    logic      load_use;
    logic      md_go;
    logic      md_last;
    logic      stall_inc;
    logic      flush_inc;

    assign load_use = load_use_hit(ex_memread, ex_rt, id_rs, id_rt, id_use_rs, id_use_rt);

`ifdef PIPE_CTRL_MULDIV_EN
    logic [MD_CNT_W-1:0] md_cnt_q;
    logic [MD_CNT_W-1:0] md_cnt_d;

    assign md_go = (state_q == RUN) && id_md_start &&
                   !ex_branch_taken && !load_use && !id_jop;

    // Counter holds remaining wait cycles including the current one, so the
    // wait ends on the cycle whose decrement brings it to zero.
    assign md_last = (state_q == MD_WAIT) && (md_cnt_q == MD_CNT_W'(1));

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_go) begin
            md_cnt_d = MD_CNT_W'(MD_LATENCY - 1);
        end else if (state_q == MD_WAIT) begin
            md_cnt_d = md_cnt_q - MD_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            md_cnt_q <= '0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end

    assign md_busy = reset && (state_q == MD_WAIT);
    assign md_done = reset && md_last;
`else
    logic unused_md;

    assign unused_md = id_md_start ^ MD_LATENCY[0];
    assign md_go     = 1'b0;
    assign md_last   = 1'b0;
    assign md_busy   = 1'b0;
    assign md_done   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (md_go)   state_d = MD_WAIT;
            MD_WAIT: if (md_last) state_d = RUN;
            default:              state_d = RUN;
        endcase
    end

    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        if (reset) begin
            unique case (state_q)
                RUN: begin
                    if (ex_branch_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        flush_inc  = 1'b1;
                    end else if (load_use) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                        stall_inc  = 1'b1;
                    end else if (id_jop) begin
                        ifid_flush = 1'b1;
                        flush_inc  = 1'b1;
                    end
                end
                MD_WAIT: begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                    stall_inc  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i  (clk),
        .clr_ni (reset),
        .inc_i  (stall_inc),
        .cnt_o  (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i  (clk),
        .clr_ni (reset),
        .inc_i  (flush_inc),
        .cnt_o  (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl; expectations follow PIPE_CTRL_MULDIV_EN.
module tb_pipeline_ctrl;

`ifdef PIPE_CTRL_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_use_rs, id_use_rt, id_jop, id_md_start;
    logic       ex_memread, ex_branch_taken;
    logic       pc_write, ifid_write, ifid_flush, idex_flush;
    logic       md_busy, md_done;
    logic [3:0] stall_cnt, flush_cnt;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.MD_LATENCY(4), .CNT_W(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_use_rs       (id_use_rs),
        .id_use_rt       (id_use_rt),
        .id_jop          (id_jop),
        .id_md_start     (id_md_start),
        .ex_memread      (ex_memread),
        .ex_rt           (ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .md_busy         (md_busy),
        .md_done         (md_done),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_use_rs = 1'b0; id_use_rt = 1'b0; id_jop = 1'b0; id_md_start = 1'b0;
        ex_memread = 1'b0; ex_branch_taken = 1'b0;
    endtask

    task automatic set_load_use();
        ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
    endtask

    task automatic check_ctrl(input string tag, input logic [3:0] exp);
        check({tag, ".ctrl"}, {28'd0, pc_write, ifid_write, ifid_flush, idex_flush}, {28'd0, exp});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        idle();
        tick();
        tick();
        check("rst.stall", stall_cnt, 0);
        check("rst.flush", flush_cnt, 0);
        check("rst.busy",  md_busy,   0);
        check("rst.done",  md_done,   0);
        ex_branch_taken = 1'b1;
        #1 check_ctrl("rst.branch_ignored", 4'b1100);
        tick();
        check("rst.flush_hold", flush_cnt, 0);

        reset = 1'b1;
        idle();
        set_load_use();
        #1 check_ctrl("lu", 4'b0001);
        tick();
        check("lu.stall", stall_cnt, 1);

        idle();
        ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
        #1 check_ctrl("lu.zero_reg", 4'b1100);
        idle();
        ex_memread = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_use_rt = 1'b0;
        #1 check_ctrl("lu.unused_rt", 4'b1100);
        id_use_rt = 1'b1;
        #1 check_ctrl("lu.used_rt", 4'b0001);
        idle();
        tick();
        check("lu.stall_hold", stall_cnt, 1);

        set_load_use();
        ex_branch_taken = 1'b1;
        id_md_start = 1'b1;
        #1 check_ctrl("br_lu", 4'b1111);
        tick();
        check("br_lu.flush", flush_cnt, 1);
        check("br_lu.stall", stall_cnt, 1);
        check("br_lu.busy",  md_busy,   0);

        idle();
        id_jop = 1'b1;
        #1 check_ctrl("jop", 4'b1110);
        tick();
        check("jop.flush", flush_cnt, 2);

        set_load_use();
        #1 check_ctrl("lu_over_jop", 4'b0001);
        tick();
        check("lu_over_jop.stall", stall_cnt, 2);
        check("lu_over_jop.flush", flush_cnt, 2);

        idle();
        id_md_start = 1'b1;
        #1 check_ctrl("md.start", 4'b1100);
        check("md.start_busy", md_busy, 0);
        tick();
        idle();
        if (MD_EN) ex_branch_taken = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            #1;
            check($sformatf("md.busy%0d", k), md_busy, MD_EN);
            check($sformatf("md.done%0d", k), md_done, MD_EN && (k == 3));
            check_ctrl($sformatf("md.wait%0d", k), MD_EN ? 4'b0001 : 4'b1100);
            tick();
        end
        idle();
        #1 check("md.after_busy", md_busy, 0);
        check("md.after_done", md_done, 0);
        check_ctrl("md.after", 4'b1100);
        check("md.stall", stall_cnt, MD_EN ? 5 : 2);
        check("md.flush", flush_cnt, 2);

        id_md_start = 1'b1;
        tick();
        idle();
        check("mdrst.busy1", md_busy, MD_EN);
        tick();
        check("mdrst.busy2", md_busy, MD_EN);
        reset = 1'b0;
        #1 check("mdrst.done_in_rst", md_done, 0);
        tick();
        reset = 1'b1;
        #1 check("mdrst.busy", md_busy, 0);
        check("mdrst.stall", stall_cnt, 0);
        check("mdrst.flush", flush_cnt, 0);
        check_ctrl("mdrst", 4'b1100);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("mdrst.no_done%0d", k), md_done, 0);
        end

        set_load_use();
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 15) check("sat.at15", stall_cnt, 4'hF);
        end
        check("sat.stall", stall_cnt, 4'hF);
        check("sat.flush", flush_cnt, 0);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
